// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, write-port select record and priority/conflict helpers
package regfile_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int MAX_WR = 8;
    localparam int MAX_AW = 16;
    localparam int IDX_W  = $clog2(MAX_WR);

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } wr_sel_t;

    // Later ports overwrite earlier matches, so the highest-index enabled port wins.
    function automatic wr_sel_t f_wr_sel(input logic [MAX_WR-1:0] en,
                                         input logic [MAX_WR*MAX_AW-1:0] addr,
                                         input logic [MAX_AW-1:0] a);
        f_wr_sel = '0;
        for (int w = 0; w < MAX_WR; w++)
            if (en[w] && addr[w*MAX_AW +: MAX_AW] == a) begin
                f_wr_sel.hit = 1'b1;
                f_wr_sel.idx = IDX_W'(w);
            end
    endfunction

    function automatic logic f_conflict(input logic [MAX_WR-1:0] en,
                                        input logic [MAX_WR*MAX_AW-1:0] addr);
        f_conflict = 1'b0;
        for (int i = 0; i < MAX_WR; i++)
            for (int j = i + 1; j < MAX_WR; j++)
                if (en[i] && en[j] && addr[i*MAX_AW +: MAX_AW] == addr[j*MAX_AW +: MAX_AW])
                    f_conflict = 1'b1;
    endfunction
endpackage

// File: rtl/regfile_wr_sel.sv
// regfile_wr_sel: priority select of the write port targeting one address
module regfile_wr_sel #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int NUM_WR = 1
) (
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]        addr,
    output logic                     hit,
    output logic [DATA_W-1:0]        data
);
    import regfile_pkg::*;

    logic [MAX_WR-1:0]        en_p;
    logic [MAX_WR*MAX_AW-1:0] addr_p;
    wr_sel_t                  sel;

    always_comb begin
        en_p   = '0;
        addr_p = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            en_p[w]                     = wr_en[w];
            addr_p[w*MAX_AW +: MAX_AW]  = MAX_AW'(wr_addr[w*ADDR_W +: ADDR_W]);
        end
        sel  = f_wr_sel(en_p, addr_p, MAX_AW'(addr));
        hit  = sel.hit;
        data = wr_data[int'(sel.idx)*DATA_W +: DATA_W];
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with optional bypass, zero register and error pulses
module regfile_mp #(
    parameter int DATA_W    = regfile_pkg::DATA_W,
    parameter int ADDR_W    = regfile_pkg::ADDR_W,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 1,
    parameter int BYPASS    = 1,
    parameter int RESET_IDX = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic                     zero_wr_err,
    output logic                     wr_conflict
);
    import regfile_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]        regs [DEPTH];
    logic [MAX_WR-1:0]        en_p;
    logic [MAX_WR*MAX_AW-1:0] addr_p;
    logic                     zero_hit;
    logic                     conflict;

    assign regs[0] = '0;

    for (genvar i = 1; i < DEPTH; i++) begin : g_reg
        logic              hit;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] q;
        regfile_wr_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_sel (
            .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
            .addr(ADDR_W'(i)), .hit(hit), .data(d)
        );
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) q <= RESET_IDX != 0 ? DATA_W'(i) : '0;
            else if (hit) q <= d;
        assign regs[i] = q;
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic              hit;
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[p*ADDR_W +: ADDR_W];
        regfile_wr_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_byp (
            .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
            .addr(a), .hit(hit), .data(d)
        );
        assign rd_data[p*DATA_W +: DATA_W] = a == '0 ? '0 : (BYPASS != 0 && hit) ? d : regs[a];
    end

    always_comb begin
        en_p     = '0;
        addr_p   = '0;
        zero_hit = 1'b0;
        for (int w = 0; w < NUM_WR; w++) begin
            en_p[w]                    = wr_en[w];
            addr_p[w*MAX_AW +: MAX_AW] = MAX_AW'(wr_addr[w*ADDR_W +: ADDR_W]);
            zero_hit                   = zero_hit | (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == '0);
        end
        conflict = f_conflict(en_p, addr_p);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            zero_wr_err <= 1'b0;
            wr_conflict <= 1'b0;
        end else begin
            zero_wr_err <= zero_hit;
            wr_conflict <= conflict;
        end
endmodule
